// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipe_chain skid-buffer register chain.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

    // Width that can count 0..2*stages held entries.
    function automatic int occ_width(input int stages);
        return $clog2(2 * stages + 1);
    endfunction

endpackage

// File: rtl/pipe_chain_if.sv
// Upstream/downstream valid/ready bundle for pipe_chain; slave is the chain side.
interface pipe_chain_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_skid_stage.sv
// One skid-buffer stage: main + skid entry, ready taken straight from the state flop.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready
);
    stage_state_e     r_state;
    stage_state_e     w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             w_acc;
    logic             w_pop;
    logic             w_ld_main;
    logic             w_ld_skid;
    logic             w_mv_skid;

    assign o_ready = (r_state != FULL);
    assign o_valid = (r_state != EMPTY);
    assign o_data  = r_main;
    assign w_acc   = i_valid & o_ready;
    assign w_pop   = o_valid & i_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= EMPTY;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ld_main   = 1'b0;
        w_ld_skid   = 1'b0;
        w_mv_skid   = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_acc) begin
                    w_state_nxt = BUSY;
                    w_ld_main   = 1'b1;
                end
            end
            BUSY: begin
                if (w_acc && !w_pop) begin
                    w_state_nxt = FULL;
                    w_ld_skid   = 1'b1;
                end else if (w_acc && w_pop) begin
                    w_ld_main   = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (w_pop) begin
                    w_state_nxt = BUSY;
                    w_mv_skid   = 1'b1;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
        if (flush) w_state_nxt = EMPTY;
    end

    // Flush only drops valid state; payload registers keep their contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main <= '0;
            r_skid <= '0;
        end else if (!flush) begin
            if (w_ld_main)      r_main <= i_data;
            else if (w_mv_skid) r_main <= r_skid;
            if (w_ld_skid)      r_skid <= i_data;
        end
    end

endmodule

// File: rtl/pipe_chain.sv
// STAGES cascaded skid stages with flush; PIPE_CHAIN_OCC_EN adds the occupancy port/counter.
module pipe_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    pipe_chain_if.slave bus
`ifdef PIPE_CHAIN_OCC_EN
    ,
    output logic [occ_width(STAGES)-1:0] occupancy
`endif
);
    logic [STAGES:0]            w_vld;
    logic [STAGES:0]            w_rdy;
    logic [STAGES:0][WIDTH-1:0] w_data;

    assign w_vld[0]      = bus.in_valid;
    assign w_data[0]     = bus.in_data;
    assign w_rdy[STAGES] = bus.out_ready;
    // Flush gating is the only combinational input-to-ready path.
    assign bus.in_ready  = w_rdy[0] & ~flush;
    assign bus.out_valid = w_vld[STAGES];
    assign bus.out_data  = w_data[STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipe_skid_stage #(.WIDTH(WIDTH)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush),
            .i_valid (w_vld[k]),
            .i_data  (w_data[k]),
            .o_ready (w_rdy[k]),
            .o_valid (w_vld[k+1]),
            .o_data  (w_data[k+1]),
            .i_ready (w_rdy[k+1])
        );
    end

`ifdef PIPE_CHAIN_OCC_EN
    localparam int OW = occ_width(STAGES);
    logic [OW-1:0] r_occ;
    logic          w_in_xfer;
    logic          w_out_xfer;

    assign w_in_xfer  = bus.in_valid & bus.in_ready;
    assign w_out_xfer = bus.out_valid & bus.out_ready;
    assign occupancy  = r_occ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          r_occ <= '0;
        else if (flush)                   r_occ <= '0;
        else if (w_in_xfer && !w_out_xfer) r_occ <= r_occ + 1'b1;
        else if (w_out_xfer && !w_in_xfer) r_occ <= r_occ - 1'b1;
    end
`endif

endmodule
